nvme_qp_doorbell_arb: RTL and testbench

Multi-queue-pair NVMe doorbell manager sitting between the NVMe back end and the PIO doorbell FIFOs. It tracks the SQ tail and CQ head pointers for NUM_QP queue pairs, enforces per-queue SQ occupancy limits, and coalesces pending pointer updates. Two independent round-robin arbiters issue at most one SQ doorbell and one CQ doorbell write per handshake toward PIO. It generalises the single-queue doorbell path to multiple queue pairs with flow control and coalescing.

---
 rtl/nvme_qp_doorbell_arb.sv | 218 +++++++++++++++++++++
 tb/tb_nvme_qp_doorbell_arb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/nvme_qp_doorbell_arb.sv
// Multi-queue-pair NVMe SQ-tail / CQ-head doorbell tracker with coalescing and two round-robin issuers; optional hold timer under NVME_DB_COALESCE_TIMER_EN.
// Update in cycle N -> doorbell valid at N+2 earliest; valid/outputs held until ready, one idle cycle between doorbells; sq_push_ready drops at QDEPTH-1 in flight.
module nvme_qp_doorbell_arb #(
    parameter  int NUM_QP = 4,
    parameter  int QDEPTH = 64,
    localparam int QID_W  = (NUM_QP > 1) ? $clog2(NUM_QP) : 1,
    localparam int PTR_W  = $clog2(QDEPTH)
) (
    input  logic                        axi4_mm_clk,
    input  logic                        axi4_mm_rst_n,
    input  logic                        i_clear,
    input  logic [63:0]                 i_delay_cnt,
    input  logic [NUM_QP-1:0]           sq_push_valid,
    output logic [NUM_QP-1:0]           sq_push_ready,
    input  logic [NUM_QP-1:0]           cq_pop_valid,
    output logic                        pio_sqdb_valid,
    input  logic                        pio_sqdb_ready,
    output logic [QID_W-1:0]            pio_sqdb_qid,
    output logic [63:0]                 pio_sqdb_tail,
    output logic                        pio_cqdb_valid,
    input  logic                        pio_cqdb_ready,
    output logic [QID_W-1:0]            pio_cqdb_qid,
    output logic [63:0]                 pio_cqdb_head,
    output logic [NUM_QP*(PTR_W+1)-1:0] o_outstanding,
    output logic                        o_err_underflow
);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} st_e;

    logic [PTR_W-1:0]  r_sq_tail [NUM_QP];
    logic [PTR_W-1:0]  r_cq_head [NUM_QP];
    logic [PTR_W:0]    r_outst   [NUM_QP];
    logic [NUM_QP-1:0] r_sq_dirty, r_cq_dirty;
    logic [NUM_QP-1:0] w_push, w_pop, w_ozero;
    logic [NUM_QP-1:0] w_sq_elig, w_cq_elig, w_sq_clr, w_cq_clr;

    st_e               r_sq_st, w_sq_nxt, r_cq_st, w_cq_nxt;
    logic              w_sq_load, w_cq_load, w_sq_found, w_cq_found;
    logic [QID_W-1:0]  w_sq_pick, w_cq_pick, r_rr_sq, r_rr_cq;
    logic [QID_W-1:0]  r_sqdb_qid, r_cqdb_qid;
    logic [PTR_W-1:0]  r_sqdb_tail, r_cqdb_head;
    logic              r_err;

    // First requester at or after rr, wrapping; returns {found, qid}.
    function automatic logic [QID_W:0] rr_pick(input logic [NUM_QP-1:0] req,
                                               input logic [QID_W-1:0]  rr);
        logic             found;
        logic [QID_W-1:0] q;
        int               idx;
        found = 1'b0;
        q     = '0;
        for (int i = NUM_QP - 1; i >= 0; i--) begin
            idx = int'(rr) + i;
            if (idx >= NUM_QP) idx = idx - NUM_QP;
            if (req[idx]) begin
                found = 1'b1;
                q     = QID_W'(idx);
            end
        end
        return {found, q};
    endfunction

    function automatic logic [QID_W-1:0] rr_next(input logic [QID_W-1:0] q);
        return (q == QID_W'(NUM_QP - 1)) ? '0 : q + QID_W'(1);
    endfunction

    genvar g;
    generate
        for (g = 0; g < NUM_QP; g++) begin : g_q
            assign w_ozero[g]       = (r_outst[g] == '0);
            assign sq_push_ready[g] = (r_outst[g] < (PTR_W+1)'(QDEPTH - 1));
            assign w_push[g]        = sq_push_valid[g] & sq_push_ready[g] & ~i_clear;
            assign w_pop[g]         = cq_pop_valid[g] & ~w_ozero[g] & ~i_clear;
            assign w_sq_clr[g]      = w_sq_load & (w_sq_pick == QID_W'(g));
            assign w_cq_clr[g]      = w_cq_load & (w_cq_pick == QID_W'(g));
            assign o_outstanding[g*(PTR_W+1) +: (PTR_W+1)] = r_outst[g];

            always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
                if (!axi4_mm_rst_n) begin
                    r_sq_tail[g]  <= '0;
                    r_cq_head[g]  <= '0;
                    r_outst[g]    <= '0;
                    r_sq_dirty[g] <= 1'b0;
                    r_cq_dirty[g] <= 1'b0;
                end else if (i_clear) begin
                    r_sq_tail[g]  <= '0;
                    r_cq_head[g]  <= '0;
                    r_outst[g]    <= '0;
                    r_sq_dirty[g] <= 1'b0;
                    r_cq_dirty[g] <= 1'b0;
                end else begin
                    if (w_push[g]) r_sq_tail[g] <= r_sq_tail[g] + PTR_W'(1);
                    if (w_pop[g])  r_cq_head[g] <= r_cq_head[g] + PTR_W'(1);
                    if (w_push[g] && !w_pop[g])
                        r_outst[g] <= r_outst[g] + (PTR_W+1)'(1);
                    else if (!w_push[g] && w_pop[g])
                        r_outst[g] <= r_outst[g] - (PTR_W+1)'(1);
                    // A fresh update in the load cycle keeps the queue dirty.
                    if (w_push[g])        r_sq_dirty[g] <= 1'b1;
                    else if (w_sq_clr[g]) r_sq_dirty[g] <= 1'b0;
                    if (w_pop[g])         r_cq_dirty[g] <= 1'b1;
                    else if (w_cq_clr[g]) r_cq_dirty[g] <= 1'b0;
                end
            end
        end
    endgenerate

`ifdef NVME_DB_COALESCE_TIMER_EN
    logic [63:0] r_sq_tmr [NUM_QP];
    logic [63:0] r_cq_tmr [NUM_QP];
    generate
        for (g = 0; g < NUM_QP; g++) begin : g_tmr
            assign w_sq_elig[g] = r_sq_dirty[g] & ((i_delay_cnt == 64'd0) | (r_sq_tmr[g] >= i_delay_cnt));
            assign w_cq_elig[g] = r_cq_dirty[g] & ((i_delay_cnt == 64'd0) | (r_cq_tmr[g] >= i_delay_cnt));
            always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
                if (!axi4_mm_rst_n) begin
                    r_sq_tmr[g] <= '0;
                    r_cq_tmr[g] <= '0;
                end else begin
                    if (i_clear || !r_sq_dirty[g] || w_sq_clr[g]) r_sq_tmr[g] <= '0;
                    else if (r_sq_tmr[g] < i_delay_cnt)            r_sq_tmr[g] <= r_sq_tmr[g] + 64'd1;
                    if (i_clear || !r_cq_dirty[g] || w_cq_clr[g]) r_cq_tmr[g] <= '0;
                    else if (r_cq_tmr[g] < i_delay_cnt)            r_cq_tmr[g] <= r_cq_tmr[g] + 64'd1;
                end
            end
        end
    endgenerate
`else
    logic w_unused_delay;
    assign w_unused_delay = ^i_delay_cnt;
    assign w_sq_elig      = r_sq_dirty;
    assign w_cq_elig      = r_cq_dirty;
`endif

    assign {w_sq_found, w_sq_pick} = rr_pick(w_sq_elig, r_rr_sq);
    assign {w_cq_found, w_cq_pick} = rr_pick(w_cq_elig, r_rr_cq);

    always_comb begin
        w_sq_nxt  = r_sq_st;
        w_sq_load = 1'b0;
        case (r_sq_st)
            ST_IDLE: if (w_sq_found) begin
                w_sq_load = 1'b1;
                w_sq_nxt  = ST_BUSY;
            end
            ST_BUSY: if (pio_sqdb_ready) w_sq_nxt = ST_IDLE;
            default: w_sq_nxt = ST_IDLE;
        endcase
        if (i_clear) begin
            w_sq_nxt  = ST_IDLE;
            w_sq_load = 1'b0;
        end
    end

    always_comb begin
        w_cq_nxt  = r_cq_st;
        w_cq_load = 1'b0;
        case (r_cq_st)
            ST_IDLE: if (w_cq_found) begin
                w_cq_load = 1'b1;
                w_cq_nxt  = ST_BUSY;
            end
            ST_BUSY: if (pio_cqdb_ready) w_cq_nxt = ST_IDLE;
            default: w_cq_nxt = ST_IDLE;
        endcase
        if (i_clear) begin
            w_cq_nxt  = ST_IDLE;
            w_cq_load = 1'b0;
        end
    end

    always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
        if (!axi4_mm_rst_n) begin
            r_sq_st     <= ST_IDLE;
            r_cq_st     <= ST_IDLE;
            r_rr_sq     <= '0;
            r_rr_cq     <= '0;
            r_sqdb_qid  <= '0;
            r_cqdb_qid  <= '0;
            r_sqdb_tail <= '0;
            r_cqdb_head <= '0;
            r_err       <= 1'b0;
        end else begin
            r_sq_st <= w_sq_nxt;
            r_cq_st <= w_cq_nxt;
            if (i_clear) begin
                r_rr_sq     <= '0;
                r_rr_cq     <= '0;
                r_sqdb_qid  <= '0;
                r_cqdb_qid  <= '0;
                r_sqdb_tail <= '0;
                r_cqdb_head <= '0;
                r_err       <= 1'b0;
            end else begin
                if (w_sq_load) begin
                    r_sqdb_qid  <= w_sq_pick;
                    r_sqdb_tail <= r_sq_tail[w_sq_pick];
                    r_rr_sq     <= rr_next(w_sq_pick);
                end
                if (w_cq_load) begin
                    r_cqdb_qid  <= w_cq_pick;
                    r_cqdb_head <= r_cq_head[w_cq_pick];
                    r_rr_cq     <= rr_next(w_cq_pick);
                end
                if (|(cq_pop_valid & w_ozero)) r_err <= 1'b1;
            end
        end
    end

    assign pio_sqdb_valid  = (r_sq_st == ST_BUSY);
    assign pio_cqdb_valid  = (r_cq_st == ST_BUSY);
    assign pio_sqdb_qid    = r_sqdb_qid;
    assign pio_cqdb_qid    = r_cqdb_qid;
    assign pio_sqdb_tail   = 64'(r_sqdb_tail);
    assign pio_cqdb_head   = 64'(r_cqdb_head);
    assign o_err_underflow = r_err;

endmodule

// File: tb/tb_nvme_qp_doorbell_arb.sv
// Directed bench for nvme_qp_doorbell_arb at NUM_QP=4, QDEPTH=64 (7-bit outstanding fields).
module tb_nvme_qp_doorbell_arb;
    logic        axi4_mm_clk = 1'b0;
    logic        axi4_mm_rst_n = 1'b0;
    logic        i_clear = 1'b0;
    logic [63:0] i_delay_cnt = 64'd0;
    logic [3:0]  sq_push_valid = 4'd0;
    logic [3:0]  sq_push_ready;
    logic [3:0]  cq_pop_valid = 4'd0;
    logic        pio_sqdb_valid, pio_cqdb_valid;
    logic        pio_sqdb_ready = 1'b0, pio_cqdb_ready = 1'b0;
    logic [1:0]  pio_sqdb_qid, pio_cqdb_qid;
    logic [63:0] pio_sqdb_tail, pio_cqdb_head;
    logic [27:0] o_outstanding;
    logic        o_err_underflow;

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    nvme_qp_doorbell_arb #(.NUM_QP(4), .QDEPTH(64)) dut (
        .axi4_mm_clk     (axi4_mm_clk),
        .axi4_mm_rst_n   (axi4_mm_rst_n),
        .i_clear         (i_clear),
        .i_delay_cnt     (i_delay_cnt),
        .sq_push_valid   (sq_push_valid),
        .sq_push_ready   (sq_push_ready),
        .cq_pop_valid    (cq_pop_valid),
        .pio_sqdb_valid  (pio_sqdb_valid),
        .pio_sqdb_ready  (pio_sqdb_ready),
        .pio_sqdb_qid    (pio_sqdb_qid),
        .pio_sqdb_tail   (pio_sqdb_tail),
        .pio_cqdb_valid  (pio_cqdb_valid),
        .pio_cqdb_ready  (pio_cqdb_ready),
        .pio_cqdb_qid    (pio_cqdb_qid),
        .pio_cqdb_head   (pio_cqdb_head),
        .o_outstanding   (o_outstanding),
        .o_err_underflow (o_err_underflow)
    );

    always #5 axi4_mm_clk = ~axi4_mm_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge axi4_mm_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ofld(input int q);
        return 64'(o_outstanding[q*7 +: 7]);
    endfunction

    task automatic clr();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    // Wait (bounded) for a doorbell, check it, complete the handshake.
    task automatic db_take(input bit cq, input logic [1:0] eq, input logic [63:0] ev, input string tag);
        int n = 0;
        while (((cq ? pio_cqdb_valid : pio_sqdb_valid) == 1'b0) && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, 64'(cq ? pio_cqdb_valid : pio_sqdb_valid), 64'd1);
        chk({tag, "_qid"}, 64'(cq ? pio_cqdb_qid : pio_sqdb_qid), 64'(eq));
        chk({tag, "_ptr"}, cq ? pio_cqdb_head : pio_sqdb_tail, ev);
        if (cq) pio_cqdb_ready = 1'b1; else pio_sqdb_ready = 1'b1;
        tick();
        pio_cqdb_ready = 1'b0;
        pio_sqdb_ready = 1'b0;
        chk({tag, "_drop"}, 64'(cq ? pio_cqdb_valid : pio_sqdb_valid), 64'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_sq_vld", 64'(pio_sqdb_valid), 64'd0);
        chk("rst_cq_vld", 64'(pio_cqdb_valid), 64'd0);
        chk("rst_sq_qid", 64'(pio_sqdb_qid), 64'd0);
        chk("rst_sq_tail", pio_sqdb_tail, 64'd0);
        chk("rst_cq_head", pio_cqdb_head, 64'd0);
        chk("rst_ready", 64'(sq_push_ready), 64'hF);
        chk("rst_outst", 64'(o_outstanding), 64'd0);
        chk("rst_err", 64'(o_err_underflow), 64'd0);
        axi4_mm_rst_n = 1'b1;
        tick();

        // Single push on q2: valid two edges later, held while ready low
        sq_push_valid = 4'b0100;
        tick();
        sq_push_valid = 4'b0000;
        chk("t1_vld_n1", 64'(pio_sqdb_valid), 64'd0);
        tick();
        chk("t1_vld_n2", 64'(pio_sqdb_valid), 64'd1);
        chk("t1_qid", 64'(pio_sqdb_qid), 64'd2);
        chk("t1_tail", pio_sqdb_tail, 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_hold_vld", 64'(pio_sqdb_valid), 64'd1);
            chk("t1_hold_qid", 64'(pio_sqdb_qid), 64'd2);
            chk("t1_hold_tail", pio_sqdb_tail, 64'd1);
        end
        chk("t1_outst_q2", ofld(2), 64'd1);
        pio_sqdb_ready = 1'b1;
        tick();
        pio_sqdb_ready = 1'b0;
        chk("t1_drop", 64'(pio_sqdb_valid), 64'd0);
        clr();
        chk("t1_clr_outst", 64'(o_outstanding), 64'd0);

        // Coalescing: 5 pushes on q1 while its first doorbell is stalled
        sq_push_valid = 4'b0010;
        tick();
        sq_push_valid = 4'b0000;
        tick();
        chk("t2_busy_vld", 64'(pio_sqdb_valid), 64'd1);
        sq_push_valid = 4'b0010;
        repeat (5) tick();
        sq_push_valid = 4'b0000;
        chk("t2_frozen_tail", pio_sqdb_tail, 64'd1);
        db_take(1'b0, 2'd1, 64'd1, "t2_first");
        db_take(1'b0, 2'd1, 64'd6, "t2_coal");
        repeat (3) tick();
        chk("t2_no_extra", 64'(pio_sqdb_valid), 64'd0);
        chk("t2_outst_q1", ofld(1), 64'd6);

        // i_clear mid-handshake drops valid
        sq_push_valid = 4'b0001;
        tick();
        sq_push_valid = 4'b0000;
        tick();
        chk("tc_vld", 64'(pio_sqdb_valid), 64'd1);
        clr();
        chk("tc_drop", 64'(pio_sqdb_valid), 64'd0);
        chk("tc_tail", pio_sqdb_tail, 64'd0);

        // Round robin
        sq_push_valid = 4'hF;
        tick();
        sq_push_valid = 4'h0;
        for (int k = 0; k < 4; k++) db_take(1'b0, 2'(k), 64'd1, "t3_rr");
        sq_push_valid = 4'b1001;
        tick();
        sq_push_valid = 4'h0;
        db_take(1'b0, 2'd0, 64'd2, "t3_q0");
        db_take(1'b0, 2'd3, 64'd2, "t3_q3");
        clr();

        // Occupancy limit, pointer wrap
        sq_push_valid = 4'b0001;
        repeat (63) tick();
        chk("t4_ready_full", 64'(sq_push_ready), 64'hE);
        chk("t4_outst_63", ofld(0), 64'd63);
        tick();
        sq_push_valid = 4'b0000;
        chk("t4_refused", ofld(0), 64'd63);
        cq_pop_valid = 4'b0001;
        tick();
        cq_pop_valid = 4'b0000;
        chk("t4_ready_back", 64'(sq_push_ready), 64'hF);
        chk("t4_outst_62", ofld(0), 64'd62);
        db_take(1'b1, 2'd0, 64'd1, "t4_cq_head");
        db_take(1'b0, 2'd0, 64'd1, "t4_sq_first");
        db_take(1'b0, 2'd0, 64'd63, "t4_sq_63");
        sq_push_valid = 4'b0001;
        tick();
        sq_push_valid = 4'b0000;
        db_take(1'b0, 2'd0, 64'd0, "t4_wrap");
        chk("t4_outst_end", ofld(0), 64'd63);
        clr();

        // Underflow
        cq_pop_valid = 4'b1000;
        tick();
        cq_pop_valid = 4'b0000;
        chk("t5_err", 64'(o_err_underflow), 64'd1);
        chk("t5_outst_q3", ofld(3), 64'd0);
        tick();
        tick();
        chk("t5_no_cqdb", 64'(pio_cqdb_valid), 64'd0);
        sq_push_valid = 4'b1000;
        tick();
        sq_push_valid = 4'b0000;
        cq_pop_valid = 4'b1000;
        tick();
        cq_pop_valid = 4'b0000;
        db_take(1'b1, 2'd3, 64'd1, "t5_head");
        chk("t5_err_sticky", 64'(o_err_underflow), 64'd1);
        sq_push_valid = 4'b0100;
        tick();
        cq_pop_valid = 4'b0100;
        tick();
        sq_push_valid = 4'b0000;
        cq_pop_valid = 4'b0000;
        chk("t5_pushpop", ofld(2), 64'd1);
        clr();
        chk("t5_err_clr", 64'(o_err_underflow), 64'd0);
        chk("t5_outst_clr", 64'(o_outstanding), 64'd0);

        // Hold timer latency
        i_delay_cnt = 64'd10;
        sq_push_valid = 4'b0010;
        tick();
        sq_push_valid = 4'b0000;
        lat = 1;
        while (!pio_sqdb_valid && lat < 40) begin
            tick();
            lat++;
        end
`ifdef NVME_DB_COALESCE_TIMER_EN
        chk("t6_latency", 64'(lat), 64'd12);
`else
        chk("t6_latency", 64'(lat), 64'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
